// File: rtl/hex_display_arbiter.sv
// Two-requester round-robin arbiter that owns an eight-digit hex display.
// A winner is granted for one cycle, then holds the display for HOLD_CYCLES cycles.
module hex_display_arbiter #(
    parameter logic [31:0] HOLD_CYCLES = 32'd50_000_000,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [1:0]  req_i,
    input  logic [31:0] data0_i,
    input  logic [31:0] data1_i,
    output logic [1:0]  grant_o,
    output logic [1:0]  ack_o,
    output logic [31:0] display_o,
    output logic        owner_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  ack_q, ack_d;
    logic [31:0] display_q, display_d;
    logic        owner_q, owner_d;
    logic        busy_q, busy_d;
    logic        last_q, last_d;
    logic        win_q, win_d;
    logic [31:0] cnt_q, cnt_d;

    logic        winner_c;
    logic [31:0] win_data_c;
    logic [31:0] owner_data_c;

    // On a tie the requester that was not served last wins.
    assign winner_c     = (req_i == 2'b11) ? ~last_q : req_i[1];
    assign win_data_c   = win_q   ? data1_i : data0_i;
    assign owner_data_c = owner_q ? data1_i : data0_i;

    always_comb begin
        state_d   = state_q;
        grant_d   = 2'b00;
        ack_d     = 2'b00;
        display_d = display_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        last_d    = last_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_i != 2'b00) begin
                    state_d = S_GRANT;
                    win_d   = winner_c;
                    grant_d = winner_c ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_GRANT: begin
                if (req_i[win_q]) begin
                    state_d   = S_HOLD;
                    display_d = win_data_c;
                    owner_d   = win_q;
                    last_d    = win_q;
                    cnt_d     = HOLD_CYCLES - 32'd1;
                    ack_d     = win_q ? 2'b10 : 2'b01;
                    busy_d    = 1'b1;
                end else begin
                    // Requester withdrew before the update: drop the grant silently.
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_HOLD: begin
                if (req_i[owner_q]) begin
                    display_d = owner_data_c;
                    ack_d     = owner_q ? 2'b10 : 2'b01;
                end
                // Refreshes never reload the counter, so the hold cannot be extended.
                if (cnt_q == 32'd0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            grant_q   <= 2'b00;
            ack_q     <= 2'b00;
            display_q <= RESET_VALUE;
            owner_q   <= 1'b0;
            busy_q    <= 1'b0;
            last_q    <= 1'b1;
            win_q     <= 1'b0;
            cnt_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            display_q <= display_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            last_q    <= last_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
        end
    end

    assign grant_o   = grant_q;
    assign ack_o     = ack_q;
    assign display_o = display_q;
    assign owner_o   = owner_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Randomized check of hex_display_arbiter against a timestamp-based reference model.
module tb_hex_display_arbiter;

    localparam int H = 4;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [1:0]  req_i   = 2'b00;
    logic [31:0] data0_i = 32'h0;
    logic [31:0] data1_i = 32'h0;
    logic [1:0]  grant_o;
    logic [1:0]  ack_o;
    logic [31:0] display_o;
    logic        owner_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    hex_display_arbiter #(
        .HOLD_CYCLES(32'd4),
        .RESET_VALUE(32'h0000_0000)
    ) dut (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .req_i    (req_i),
        .data0_i  (data0_i),
        .data1_i  (data1_i),
        .grant_o  (grant_o),
        .ack_o    (ack_o),
        .display_o(display_o),
        .owner_o  (owner_o),
        .busy_o   (busy_o)
    );

    always #5 clock_i = ~clock_i;

    // Reference model: an operation is an arbitration at edge m_n; the update
    // happens at edge m_n+1 and the display is released at edge m_n+1+H.
    int          ecount;
    int          m_n;
    bit          m_active;
    bit          m_w;
    bit          m_last;
    bit          m_owner;
    bit          m_busy;
    logic [1:0]  m_grant;
    logic [1:0]  m_ack;
    logic [31:0] m_display;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_last    = 1'b1;
        m_owner   = 1'b0;
        m_busy    = 1'b0;
        m_grant   = 2'b00;
        m_ack     = 2'b00;
        m_display = 32'h0;
    endtask

    task automatic model_edge(input logic [1:0] req, input logic [31:0] d0, input logic [31:0] d1);
        ecount++;
        m_grant = 2'b00;
        m_ack   = 2'b00;
        if (!m_active) begin
            if (req != 2'b00) begin
                if (req == 2'b11) m_w = !m_last;
                else              m_w = (req == 2'b10);
                m_n      = ecount;
                m_active = 1'b1;
                m_grant  = m_w ? 2'b10 : 2'b01;
                m_busy   = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end else if (ecount == m_n + 1) begin
            if (req[m_w]) begin
                m_display = m_w ? d1 : d0;
                m_owner   = m_w;
                m_last    = m_w;
                m_ack     = m_w ? 2'b10 : 2'b01;
            end else begin
                m_active = 1'b0;
                m_busy   = 1'b0;
            end
        end else begin
            if (req[m_owner]) begin
                m_display = m_owner ? d1 : d0;
                m_ack     = m_owner ? 2'b10 : 2'b01;
            end
            if (ecount == m_n + 1 + H) begin
                m_active = 1'b0;
                m_busy   = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string phase);
        chk({phase, ":grant"},   {30'd0, grant_o}, {30'd0, m_grant});
        chk({phase, ":ack"},     {30'd0, ack_o},   {30'd0, m_ack});
        chk({phase, ":display"}, display_o,        m_display);
        chk({phase, ":owner"},   {31'd0, owner_o}, {31'd0, m_owner});
        chk({phase, ":busy"},    {31'd0, busy_o},  {31'd0, m_busy});
    endtask

    task automatic do_cycle(input string phase);
        @(posedge clock_i);
        model_edge(req_i, data0_i, data1_i);
        #1;
        check_all(phase);
        if (m_ack != 2'b00)
            $display("update t=%0t owner=%0d ack=%b display=%h", $time, m_owner, m_ack, m_display);
    endtask

    task automatic async_reset_pulse();
        reset_i = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clock_i);
        reset_i = 1'b0;
    endtask

    logic [1:0] r;

    initial begin
        ecount = 0;
        m_n    = 0;
        m_w    = 1'b0;
        model_reset();
        #2;
        check_all("rst_init");
        @(negedge clock_i);
        reset_i = 1'b0;

        // Single requester held for one full operation, then released.
        req_i   = 2'b01;
        data0_i = 32'h1234_5678;
        for (int i = 0; i < 8; i++) do_cycle("single");
        @(negedge clock_i);
        req_i = 2'b00;
        do_cycle("single_idle");

        // Abort: request present only at the arbitration edge.
        @(negedge clock_i);
        req_i = 2'b01;
        do_cycle("abort");
        @(negedge clock_i);
        req_i = 2'b00;
        for (int i = 0; i < 2; i++) do_cycle("abort");

        // Contention held continuously.
        @(negedge clock_i);
        req_i   = 2'b11;
        data0_i = 32'hAAAA_0000;
        data1_i = 32'h0000_BBBB;
        for (int i = 0; i < 20; i++) do_cycle("contend");

        // Refresh by the owner during hold while requester 1 waits.
        @(negedge clock_i);
        async_reset_pulse();
        req_i = 2'b01;
        data0_i = 32'h1111_1111;
        do_cycle("refresh");
        do_cycle("refresh");
        @(negedge clock_i);
        req_i   = 2'b11;
        data0_i = 32'hCAFE_F00D;
        for (int i = 0; i < 10; i++) do_cycle("refresh");

        // Reset during the second hold cycle.
        @(negedge clock_i);
        req_i = 2'b10;
        do_cycle("rst_hold");
        do_cycle("rst_hold");
        do_cycle("rst_hold");
        @(negedge clock_i);
        async_reset_pulse();
        for (int i = 0; i < 3; i++) do_cycle("rst_hold");

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock_i);
            r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 3) r = 2'b00;
            req_i = r;
            if ($urandom_range(0, 3) == 0) data0_i = $urandom;
            if ($urandom_range(0, 3) == 0) data1_i = $urandom;
            if ($urandom_range(0, 99) == 0) async_reset_pulse();
            do_cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_display_arbiter.md
HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50000000, minimum cycles an owner keeps the display; legal range 1..2^32-1.
REQ-002 SHALL have parameter RESET_VALUE, default 32'h0000_0000, the display value after reset.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: ports clock_i (1-bit input, sole clock) and reset_i (1-bit input).
REQ-004 SHALL have port req_i, input, 2 bits: per-requester display request; bit 0 = CPU GPIO, bit 1 = debug/switch source.
REQ-005 SHALL have port data0_i, input, 32 bits: requester 0 display value.
REQ-006 SHALL have port data1_i, input, 32 bits: requester 1 display value.
REQ-007 SHALL have port grant_o, output, 2 bits: one-hot grant.
REQ-008 SHALL have port ack_o, output, 2 bits: one-hot, one-cycle pulse marking a display update for that requester.
REQ-009 SHALL have port display_o, output, 32 bits: registered value driving the eight hex digits (nibble n to digit n).
REQ-010 SHALL have port owner_o, output, 1 bit: index of the last requester that updated the display.
REQ-011 SHALL have port busy_o, output, 1 bit: high while in GRANT or HOLD.

Function
REQ-012 SHALL implement the states IDLE, GRANT and HOLD; all outputs SHALL be registered.
REQ-013 In IDLE with req_i==0, the block SHALL stay in IDLE with grant_o=0 and busy_o=0.
REQ-014 In IDLE with req_i!=0 at a posedge, the block SHALL pick winner w, enter GRANT, and present grant_o[w]=1 after that edge.
REQ-015 Round-robin rule: with a single request, that requester SHALL win; with both requesting, the requester != last_served SHALL win.
REQ-016 last_served SHALL reset to 1, so requester 0 wins the first tie after reset.
REQ-017 GRANT SHALL last exactly one cycle.
REQ-018 At the GRANT posedge with req_i[w]=1, the block SHALL load display_o with data_w, owner_o with w, last_served with w, and the counter with HOLD_CYCLES-1, pulse ack_o[w] for the next cycle, and enter HOLD.
REQ-019 At the GRANT posedge with req_i[w]=0 (abort), the block SHALL leave display_o, owner_o, last_served and ack_o unchanged and return to IDLE.
REQ-020 grant_o SHALL be 0 in HOLD.
REQ-021 In HOLD, the counter SHALL decrement each cycle; at counter==0 the block SHALL go to IDLE on that edge.
REQ-022 HOLD SHALL therefore last exactly HOLD_CYCLES cycles.
REQ-023 HOLD refresh: if req_i[owner]=1 at a HOLD posedge, the block SHALL load display_o with data_owner and pulse ack_o[owner]; the counter SHALL NOT be reloaded, so the hold is never extended.
REQ-024 In HOLD, req_i[!owner] SHALL be ignored; it is served at the next IDLE arbitration, so neither requester can starve.
REQ-025 Latency: req sampled at edge N -> grant_o after edge N -> display_o and ack_o after edge N+1 -> IDLE after edge N+1+HOLD_CYCLES.
REQ-026 A continuously requesting single requester SHALL be re-granted every HOLD_CYCLES+2 cycles.
REQ-027 The counter SHALL be 32 bits wide, with no wrap; decrement SHALL occur only while in HOLD.
REQ-028 ack_o SHALL never have both bits set, and SHALL never be high for two consecutive cycles from a single update.

Reset
REQ-029 When reset_i=1, the block SHALL immediately (asynchronously) force: state=IDLE, grant_o=0, ack_o=0, busy_o=0, owner_o=0, display_o=RESET_VALUE, counter=0, last_served=1.
REQ-030 A reset asserted mid-GRANT or mid-HOLD SHALL discard the operation with no ack.
REQ-031 The first arbitration SHALL occur at the first posedge after reset_i falls.

Verification (HOLD_CYCLES=4, RESET_VALUE=0)
REQ-032 Reset: assert reset_i between edges -> outputs 0 before the next edge, display_o=0x00000000.
REQ-033 Single requester: req_i=01, data0_i=0x12345678 -> grant_o=01 one cycle, display_o=0x12345678, ack_o=01 one cycle, busy_o high 5 cycles, next grant 6 cycles after the first.
REQ-034 Contention: req_i=11 held from reset, data0_i=0xAAAA0000, data1_i=0x0000BBBB -> display alternates 0xAAAA0000, 0x0000BBBB, 0xAAAA0000, with grants every 6 cycles.
REQ-035 Abort: req_i=01 for one cycle only -> grant_o=01 one cycle, no ack, display_o unchanged, next tie still won by requester 0.
REQ-036 Refresh: owner 0 in HOLD changes data0_i to 0xCAFEF00D with req_i[0]=1 -> display_o=0xCAFEF00D next cycle, ack_o=01, HOLD end cycle unchanged, req_i[1] not served until after IDLE.
REQ-037 Reset in HOLD: reset_i pulsed at the second HOLD cycle -> display_o=0 and busy_o=0 immediately; re-arbitration on the first edge after release.
